// File: rtl/delay_sched.sv
// delay_sched: shares one fixed-latency datapath between two requesters.
// Requests are arbitrated round-robin, limited by per-requester credits, and tagged
// with the requester id. A tag pipe matching the datapath latency steers each result
// back to its owner.
// Optional build macro DELAY_SCHED_STATS_EN adds grant and stall counters.
module delay_sched #(
  parameter int unsigned NumBits    = 8,
  parameter int unsigned Latency    = 4,
  parameter int unsigned MaxCredits = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [1:0]           req_valid_i,
  input  logic [2*NumBits-1:0] req_data_i,
  output logic [1:0]           req_ready_o,
  output logic                 pipe_in_valid_o,
  output logic [NumBits-1:0]   pipe_in_data_o,
  input  logic                 pipe_out_valid_i,
  input  logic [NumBits-1:0]   pipe_out_data_i,
  output logic [1:0]           resp_valid_o,
  output logic [NumBits-1:0]   resp_data_o,
  output logic                 tag_error_o
`ifdef DELAY_SCHED_STATS_EN
  ,
  output logic [31:0]          grant_count_o,
  output logic [15:0]          stall_count_o
`endif
);

  localparam int unsigned CredW = $clog2(MaxCredits + 1);
  typedef logic [CredW-1:0] cred_t;
  localparam cred_t CredMax = cred_t'(MaxCredits);

  logic [1:0]         elig, grant;
  logic               rr_last_q, rr_last_d;
  cred_t              credit_q [2];
  cred_t              credit_d [2];
  logic               pipe_in_valid_q, pipe_in_valid_d;
  logic [NumBits-1:0] pipe_in_data_q, pipe_in_data_d;
  logic               issue_id_q, issue_id_d;
  logic [Latency-1:0] tag_vld_q, tag_vld_d;
  logic [Latency-1:0] tag_id_q, tag_id_d;
  logic               ret_vld, ret_id, resp_fire;
  logic [1:0]         resp_valid_q, resp_valid_d;
  logic [NumBits-1:0] resp_data_q, resp_data_d;
  logic               tag_error_q, tag_error_d;

  // Round-robin grant from the current state; held off while in reset.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid_i[i] && (credit_q[i] != '0);
    end
    grant = 2'b00;
    if (!reset_i) begin
      if (elig == 2'b11) grant = rr_last_q ? 2'b01 : 2'b10;
      else               grant = elig;
    end
  end

  assign req_ready_o = grant;

  // Next-state: issue register, tag pipe, return steering, error flag and credits.
  always_comb begin
    rr_last_d       = rr_last_q;
    pipe_in_valid_d = |grant;
    pipe_in_data_d  = pipe_in_data_q;
    issue_id_d      = issue_id_q;
    if (|grant) begin
      rr_last_d      = grant[1];
      issue_id_d     = grant[1];
      pipe_in_data_d = grant[1] ? req_data_i[NumBits +: NumBits] : req_data_i[0 +: NumBits];
    end

    // Tag enters alongside the issued word, so its exit lines up with pipe_out.
    tag_vld_d[0] = pipe_in_valid_q;
    tag_id_d[0]  = issue_id_q;
    for (int unsigned i = 1; i < Latency; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end

    ret_vld   = tag_vld_q[Latency-1];
    ret_id    = tag_id_q[Latency-1];
    resp_fire = ret_vld && pipe_out_valid_i;

    resp_valid_d = 2'b00;
    resp_data_d  = resp_data_q;
    if (resp_fire) begin
      resp_valid_d[ret_id] = 1'b1;
      resp_data_d          = pipe_out_data_i;
    end

    tag_error_d = tag_error_q | (ret_vld != pipe_out_valid_i);

    // A returning tag frees its credit even if the datapath dropped the result.
    for (int i = 0; i < 2; i++) begin
      credit_d[i] = credit_q[i];
      if (ret_vld && (ret_id == 1'(i)) && !grant[i]) begin
        if (credit_q[i] != CredMax) credit_d[i] = credit_q[i] + cred_t'(1);
      end else if (grant[i] && !(ret_vld && (ret_id == 1'(i)))) begin
        if (credit_q[i] != '0) credit_d[i] = credit_q[i] - cred_t'(1);
      end
    end
  end

  // State registers with synchronous reset; in-flight tags are discarded on reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_last_q       <= 1'b1;
      credit_q[0]     <= CredMax;
      credit_q[1]     <= CredMax;
      pipe_in_valid_q <= 1'b0;
      pipe_in_data_q  <= '0;
      issue_id_q      <= 1'b0;
      tag_vld_q       <= '0;
      tag_id_q        <= '0;
      resp_valid_q    <= 2'b00;
      resp_data_q     <= '0;
      tag_error_q     <= 1'b0;
    end else begin
      rr_last_q       <= rr_last_d;
      credit_q[0]     <= credit_d[0];
      credit_q[1]     <= credit_d[1];
      pipe_in_valid_q <= pipe_in_valid_d;
      pipe_in_data_q  <= pipe_in_data_d;
      issue_id_q      <= issue_id_d;
      tag_vld_q       <= tag_vld_d;
      tag_id_q        <= tag_id_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      tag_error_q     <= tag_error_d;
    end
  end

  assign pipe_in_valid_o = pipe_in_valid_q;
  assign pipe_in_data_o  = pipe_in_data_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_data_o     = resp_data_q;
  assign tag_error_o     = tag_error_q;

`ifdef DELAY_SCHED_STATS_EN
  logic [15:0] grant_count_q [2];
  logic [15:0] stall_count_q;

  // Per-requester grant counters and any-valid-but-no-grant stall counter, wrapping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_count_q[0] <= '0;
      grant_count_q[1] <= '0;
      stall_count_q    <= '0;
    end else begin
      if (grant[0]) grant_count_q[0] <= grant_count_q[0] + 16'd1;
      if (grant[1]) grant_count_q[1] <= grant_count_q[1] + 16'd1;
      if ((|req_valid_i) && (grant == 2'b00)) stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign grant_count_o = {grant_count_q[1], grant_count_q[0]};
  assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_delay_sched.sv
// Directed self-checking bench for delay_sched with a 4-cycle delay-line datapath model.
module tb_delay_sched;

  localparam int unsigned Lat = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        pipe_in_valid;
  logic [7:0]  pipe_in_data;
  logic        pipe_out_valid;
  logic [7:0]  pipe_out_data;
  logic [1:0]  resp_valid;
  logic [7:0]  resp_data;
  logic        tag_error;
  logic        inject;
`ifdef DELAY_SCHED_STATS_EN
  logic [31:0] grant_count;
  logic [15:0] stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  delay_sched #(
    .NumBits    (8),
    .Latency    (Lat),
    .MaxCredits (2)
  ) u_dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .req_valid_i      (req_valid),
    .req_data_i       (req_data),
    .req_ready_o      (req_ready),
    .pipe_in_valid_o  (pipe_in_valid),
    .pipe_in_data_o   (pipe_in_data),
    .pipe_out_valid_i (pipe_out_valid),
    .pipe_out_data_i  (pipe_out_data),
    .resp_valid_o     (resp_valid),
    .resp_data_o      (resp_data),
    .tag_error_o      (tag_error)
`ifdef DELAY_SCHED_STATS_EN
    ,
    .grant_count_o    (grant_count),
    .stall_count_o    (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared datapath: plain delay line of Lat cycles, reset together with the DUT.
  logic [Lat-1:0] dp_v;
  logic [7:0]     dp_d [Lat];
  always @(posedge clk) begin
    if (reset) begin
      dp_v <= '0;
      for (int i = 0; i < Lat; i++) dp_d[i] <= '0;
    end else begin
      dp_v    <= {dp_v[Lat-2:0], pipe_in_valid};
      dp_d[0] <= pipe_in_data;
      for (int i = 1; i < Lat; i++) dp_d[i] <= dp_d[i-1];
    end
  end
  assign pipe_out_valid = dp_v[Lat-1] | inject;
  assign pipe_out_data  = dp_d[Lat-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 2'b00;
    inject    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [1:0] exp_ready, exp_resp;
  logic [7:0] exp_rdata;

  initial begin
    reset     = 1'b1;
    req_valid = 2'b11;
    req_data  = 16'h0000;
    inject    = 1'b0;
    tick();
    tick();
    #1;
    // Reset values, with both requesters asking during reset.
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_pivalid", 32'(pipe_in_valid), 32'h0);
    check_eq("rst_pidata", 32'(pipe_in_data), 32'h0);
    check_eq("rst_resp", 32'(resp_valid), 32'h0);
    check_eq("rst_rdata", 32'(resp_data), 32'h0);
    check_eq("rst_tagerr", 32'(tag_error), 32'h0);

    // Single requester: 0x11, 0x22 issued, stall, 0x33 issued when 0x11 returns.
    do_reset();
    for (int k = 0; k < 14; k++) begin
      tick();
      req_valid      = (k <= 6) ? 2'b01 : 2'b00;
      req_data[7:0]  = (k == 0) ? 8'h11 : (k == 1) ? 8'h22 : 8'h33;
      #1;
      exp_ready = (k <= 1 || k == 6) ? 2'b01 : 2'b00;
      exp_resp  = (k == 6 || k == 7 || k == 12) ? 2'b01 : 2'b00;
      exp_rdata = (k == 6) ? 8'h11 : (k == 7) ? 8'h22 : 8'h33;
      check_eq($sformatf("single_ready_k%0d", k), 32'(req_ready), 32'(exp_ready));
      check_eq($sformatf("single_resp_k%0d", k), 32'(resp_valid), 32'(exp_resp));
      if (exp_resp != 2'b00)
        check_eq($sformatf("single_rdata_k%0d", k), 32'(resp_data), 32'(exp_rdata));
      if (k == 1) begin
        check_eq("single_pivalid", 32'(pipe_in_valid), 32'h1);
        check_eq("single_pidata", 32'(pipe_in_data), 32'h11);
      end
      if (k == 4) check_eq("single_pidle", 32'(pipe_in_valid), 32'h0);
    end

    // Both valid for four cycles: grants alternate starting at requester 0.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      tick();
      req_valid = (k < 4) ? 2'b11 : 2'b00;
      req_data  = {8'(8'h20 + k), 8'(8'h10 + k)};
      #1;
      exp_ready = (k < 4) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_resp  = (k >= 6 && k <= 9) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rdata = (k == 6) ? 8'h10 : (k == 7) ? 8'h21 : (k == 8) ? 8'h12 : 8'h23;
      check_eq($sformatf("rr_ready_k%0d", k), 32'(req_ready), 32'(exp_ready));
      check_eq($sformatf("rr_resp_k%0d", k), 32'(resp_valid), 32'(exp_resp));
      if (exp_resp != 2'b00)
        check_eq($sformatf("rr_rdata_k%0d", k), 32'(resp_data), 32'(exp_rdata));
    end

    // Requester 1 at the credit boundary: return and accept land together at k6.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      tick();
      req_valid      = (k <= 8) ? 2'b10 : 2'b00;
      req_data[15:8] = (k < 2) ? 8'(8'h40 + k) : (k <= 6) ? 8'h46 : 8'(8'h40 + k);
      #1;
      exp_ready = (k <= 1 || k == 6 || k == 7) ? 2'b10 : 2'b00;
      exp_resp  = (k == 6 || k == 7 || k == 12 || k == 13) ? 2'b10 : 2'b00;
      exp_rdata = (k == 6) ? 8'h40 : (k == 7) ? 8'h41 : (k == 12) ? 8'h46 : 8'h47;
      check_eq($sformatf("cred_ready_k%0d", k), 32'(req_ready), 32'(exp_ready));
      check_eq($sformatf("cred_resp_k%0d", k), 32'(resp_valid), 32'(exp_resp));
      if (exp_resp != 2'b00)
        check_eq($sformatf("cred_rdata_k%0d", k), 32'(resp_data), 32'(exp_rdata));
    end

    // Untagged pipe_out_valid: sticky tag_error, no response.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      inject = (k == 0);
      #1;
      check_eq($sformatf("inj_tagerr_k%0d", k), 32'(tag_error), (k == 0) ? 32'h0 : 32'h1);
      check_eq($sformatf("inj_resp_k%0d", k), 32'(resp_valid), 32'h0);
    end

    // Reset with three words in flight; credits restored, first post-reset grant immediate.
    do_reset();
    for (int k = 0; k < 14; k++) begin
      tick();
      reset = (k == 3 || k == 4);
      if (k <= 2)                req_valid = 2'b11;
      else if (k <= 4)           req_valid = 2'b11;
      else if (k <= 7)           req_valid = 2'b01;
      else                       req_valid = 2'b00;
      req_data = {8'hB0, (k <= 4) ? 8'hA0 : 8'(8'h72 + k)};
      #1;
      if (k == 5) check_eq("rstmid_tagerr", 32'(tag_error), 32'h0);
      if (k >= 3) begin
        exp_ready = (k == 5 || k == 6) ? 2'b01 : 2'b00;
        exp_resp  = (k == 11 || k == 12) ? 2'b01 : 2'b00;
        exp_rdata = (k == 11) ? 8'h77 : 8'h78;
        check_eq($sformatf("rstmid_ready_k%0d", k), 32'(req_ready), 32'(exp_ready));
        check_eq($sformatf("rstmid_resp_k%0d", k), 32'(resp_valid), 32'(exp_resp));
        if (exp_resp != 2'b00)
          check_eq($sformatf("rstmid_rdata_k%0d", k), 32'(resp_data), 32'(exp_rdata));
      end
    end

`ifdef DELAY_SCHED_STATS_EN
    // Ten alternating grants in batches of 4, 4 and 2, with 1 + 2 stall cycles.
    do_reset();
    #1;
    check_eq("stats_rst_grant", grant_count, 32'h0);
    check_eq("stats_rst_stall", 32'(stall_count), 32'h0);
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < ((b == 0) ? 5 : (b == 1) ? 6 : 2); k++) begin
        tick();
        req_valid = 2'b11;
        #1;
        exp_ready = (k < 4) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
        check_eq($sformatf("stats_ready_b%0d_k%0d", b, k), 32'(req_ready), 32'(exp_ready));
      end
      for (int k = 0; k < 8; k++) begin
        tick();
        req_valid = 2'b00;
      end
    end
    #1;
    check_eq("stats_grant", grant_count, {16'd5, 16'd5});
    check_eq("stats_stall", 32'(stall_count), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
